mcycle_ctrl: RTL and testbench

MCYCLE_CTRL -- requirements
Module: mcycle_ctrl

---
 rtl/mcycle_ctrl.sv | 166 ++++++++++++++++
 tb/tb_mcycle_ctrl.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/mcycle_ctrl.sv
`default_nettype none
// ============================================================================
// mcycle_ctrl : iterative 32x32 multiply / 32/32 divide unit, 33-cycle latency
// Revision 1.0
// ============================================================================
module mcycle_ctrl (
   input  logic        CLK,
   input  logic        RESETn,
   input  logic        Start,
   input  logic [1:0]  MCycleOp,
   input  logic [31:0] Operand1,
   input  logic [31:0] Operand2,
   output logic [31:0] Result1,
   output logic [31:0] Result2,
   output logic        Busy,
   output logic        Done
);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_COMPUTE = 2'd1,
      S_FINISH  = 2'd2
   } state_t;

   localparam logic [4:0] C_LAST_ITER = 5'd31;

   state_t      r_state;
   state_t      w_state_nxt;

   logic        r_is_div;
   logic [31:0] r_opa;
   logic [63:0] r_acc;
   logic [4:0]  r_cnt;
   logic        r_neg_q;
   logic        r_neg_r;
   logic        r_div0;
   logic [31:0] r_res1;
   logic [31:0] r_res2;
   logic        r_done;

   logic        w_signed;
   logic        w_neg1;
   logic        w_neg2;
   logic [31:0] w_mag1;
   logic [31:0] w_mag2;

   logic [32:0] w_mul_sum;
   logic [63:0] w_mul_acc;
   logic [32:0] w_div_shift;
   logic [32:0] w_div_diff;
   logic        w_borrow;
   logic [63:0] w_div_acc;

   logic [63:0] w_prod;
   logic [31:0] w_quo;
   logic [31:0] w_rem;
   logic [31:0] w_fin1;
   logic [31:0] w_fin2;

   // Operand capture: signed ops work on magnitudes, signs restored at the end
   assign w_signed = ~MCycleOp[0];
   assign w_neg1   = w_signed & Operand1[31];
   assign w_neg2   = w_signed & Operand2[31];
   assign w_mag1   = w_neg1 ? (~Operand1 + 32'd1) : Operand1;
   assign w_mag2   = w_neg2 ? (~Operand2 + 32'd1) : Operand2;

   // MUL: acc = {partial product, remaining multiplier bits}, shift right each step
   assign w_mul_sum = {1'b0, r_acc[63:32]} + (r_acc[0] ? {1'b0, r_opa} : 33'd0);
   assign w_mul_acc = {w_mul_sum, r_acc[31:1]};

   // DIV: acc = {partial remainder, dividend/quotient}, shift left each step
   assign w_div_shift = {r_acc[63:32], r_acc[31]};
   assign w_div_diff  = w_div_shift - {1'b0, r_opa};
   assign w_borrow    = w_div_diff[32];
   assign w_div_acc   = {(w_borrow ? w_div_shift[31:0] : w_div_diff[31:0]),
                         r_acc[30:0], ~w_borrow};

   assign w_prod = r_neg_q ? (~r_acc + 64'd1) : r_acc;
   assign w_quo  = r_div0  ? 32'hFFFF_FFFF
                 : (r_neg_q ? (~r_acc[31:0] + 32'd1) : r_acc[31:0]);
   assign w_rem  = r_neg_r ? (~r_acc[63:32] + 32'd1) : r_acc[63:32];
   assign w_fin1 = r_is_div ? w_quo : w_prod[31:0];
   assign w_fin2 = r_is_div ? w_rem : w_prod[63:32];

   always_ff @(posedge CLK) begin
      if (!RESETn) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      Busy        = 1'b0;
      case (r_state)
         S_IDLE: begin
            Busy = Start;
            if (Start) begin
               w_state_nxt = S_COMPUTE;
            end
         end
         S_COMPUTE: begin
            Busy = 1'b1;
            if (r_cnt == C_LAST_ITER) begin
               w_state_nxt = S_FINISH;
            end
         end
         S_FINISH: begin
            Busy        = 1'b1;
            w_state_nxt = S_IDLE;
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge CLK) begin
      if (!RESETn) begin
         r_is_div <= 1'b0;
         r_opa    <= 32'd0;
         r_acc    <= 64'd0;
         r_cnt    <= 5'd0;
         r_neg_q  <= 1'b0;
         r_neg_r  <= 1'b0;
         r_div0   <= 1'b0;
         r_res1   <= 32'd0;
         r_res2   <= 32'd0;
         r_done   <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (Start) begin
                  r_is_div <= MCycleOp[1];
                  r_opa    <= MCycleOp[1] ? w_mag2 : w_mag1;
                  r_acc    <= {32'd0, (MCycleOp[1] ? w_mag1 : w_mag2)};
                  r_neg_q  <= w_neg1 ^ w_neg2;
                  r_neg_r  <= w_neg1;
                  r_div0   <= (Operand2 == 32'd0);
                  r_cnt    <= 5'd0;
               end
            end
            S_COMPUTE: begin
               r_acc <= r_is_div ? w_div_acc : w_mul_acc;
               r_cnt <= r_cnt + 5'd1;
            end
            S_FINISH: begin
               r_res1 <= w_fin1;
               r_res2 <= w_fin2;
               r_done <= 1'b1;
            end
            default: begin
               r_done <= 1'b0;
            end
         endcase
      end
   end

   assign Result1 = r_res1;
   assign Result2 = r_res2;
   assign Done    = r_done;

endmodule
`default_nettype wire

// File: tb/tb_mcycle_ctrl.sv
`default_nettype none
// ============================================================================
// tb_mcycle_ctrl : randomized self-checking bench for mcycle_ctrl
// Revision 1.0
// ============================================================================
module tb_mcycle_ctrl;

   logic        CLK      = 1'b0;
   logic        RESETn   = 1'b0;
   logic        Start    = 1'b0;
   logic [1:0]  MCycleOp = 2'd0;
   logic [31:0] Operand1 = 32'd0;
   logic [31:0] Operand2 = 32'd0;
   logic [31:0] Result1;
   logic [31:0] Result2;
   logic        Busy;
   logic        Done;

   int          total = 0;
   int          bad   = 0;
   int          cyc   = 0;
   logic [63:0] last_res = 64'd0;

   mcycle_ctrl u_dut (
      .CLK      (CLK),
      .RESETn   (RESETn),
      .Start    (Start),
      .MCycleOp (MCycleOp),
      .Operand1 (Operand1),
      .Operand2 (Operand2),
      .Result1  (Result1),
      .Result2  (Result2),
      .Busy     (Busy),
      .Done     (Done)
   );

   always #5 CLK = ~CLK;

   always @(posedge CLK) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // Reference: {Result2, Result1} straight from arithmetic definitions
   function automatic logic [63:0] model(input logic [1:0] op, input logic [31:0] a,
                                         input logic [31:0] b);
      longint      sa, sb, q, r;
      logic [63:0] res;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      case (op)
         2'd0: res = sa * sb;
         2'd1: res = {32'd0, a} * {32'd0, b};
         2'd2: begin
            if (b == 32'd0) res = {a, 32'hFFFF_FFFF};
            else begin
               q   = sa / sb;
               r   = sa % sb;
               res = {r[31:0], q[31:0]};
            end
         end
         default: begin
            if (b == 32'd0) res = {a, 32'hFFFF_FFFF};
            else            res = {a % b, a / b};
         end
      endcase
      return res;
   endfunction

   function automatic logic [31:0] pick();
      case ($urandom_range(0, 7))
         0:       return 32'd0;
         1:       return 32'h8000_0000;
         2:       return 32'hFFFF_FFFF;
         3:       return 32'd1;
         default: return $urandom;
      endcase
   endfunction

   // Called at a negedge; returns at the negedge of the Done cycle
   task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input bit hold, output int done_at);
      logic [63:0] exp;
      int          j;
      int          busy_n;
      exp      = model(op, a, b);
      MCycleOp = op;
      Operand1 = a;
      Operand2 = b;
      Start    = 1'b1;
      #1;
      chk("busy_start", 64'(Busy), 64'd1);
      @(negedge CLK);
      chk("done_clear", 64'(Done), 64'd0);
      chk("res_hold", {Result2, Result1}, last_res);
      j      = 0;
      busy_n = 0;
      while (!Done && j < 60) begin
         if (Busy) busy_n++;
         Start    = hold;
         Operand1 = $urandom;
         Operand2 = $urandom;
         MCycleOp = 2'($urandom_range(0, 3));
         @(negedge CLK);
         j++;
      end
      done_at = cyc;
      chk("latency", 64'(j), 64'd33);
      chk("busy_cycles", 64'(busy_n), 64'd33);
      chk($sformatf("result op%0d %h %h", op, a, b), {Result2, Result1}, exp);
      chk("busy_in_done", 64'(Busy), 64'(hold));
      last_res = exp;
   endtask

   initial begin
      int  t1, t2;
      bit  saw;
      RESETn = 1'b0;
      repeat (3) @(negedge CLK);
      RESETn = 1'b1;
      #1;
      chk("rst_res", {Result2, Result1}, 64'd0);
      chk("rst_done", 64'(Done), 64'd0);
      chk("rst_busy", 64'(Busy), 64'd0);
      @(negedge CLK);

      run_op(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, t1); @(negedge CLK);
      run_op(2'd0, 32'hFFFF_FFFD, 32'h0000_0005, 1'b0, t1); @(negedge CLK);
      run_op(2'd3, 32'h0000_0064, 32'h0000_0007, 1'b0, t1); @(negedge CLK);
      run_op(2'd2, 32'hFFFF_FFF9, 32'h0000_0002, 1'b0, t1); @(negedge CLK);
      run_op(2'd3, 32'h1234_5678, 32'h0000_0000, 1'b0, t1); @(negedge CLK);
      run_op(2'd2, 32'h1234_5678, 32'h0000_0000, 1'b0, t1); @(negedge CLK);
      run_op(2'd2, 32'h8765_4321, 32'h0000_0000, 1'b0, t1); @(negedge CLK);
      run_op(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, t1); @(negedge CLK);

      // Start held high across two ops: second accepted in the Done cycle
      run_op(2'd0, $urandom, $urandom, 1'b1, t1);
      run_op(2'd2, $urandom, $urandom, 1'b1, t2);
      Start = 1'b0;
      chk("done_spacing", 64'(t2 - t1), 64'd34);
      @(negedge CLK);

      for (int n = 0; n < 40; n++) begin
         run_op(2'($urandom_range(0, 3)), pick(), pick(), 1'b0, t1);
         if ($urandom_range(0, 1) == 1) @(negedge CLK);
      end
      @(negedge CLK);

      // Abort mid-computation; Start during reset must be ignored
      MCycleOp = 2'd1;
      Operand1 = 32'hDEAD_BEEF;
      Operand2 = 32'h1234_5678;
      Start    = 1'b1;
      @(negedge CLK);
      Start = 1'b0;
      repeat (10) @(negedge CLK);
      RESETn = 1'b0;
      Start  = 1'b1;
      @(negedge CLK);
      RESETn = 1'b1;
      Start  = 1'b0;
      #1;
      chk("abort_busy", 64'(Busy), 64'd0);
      chk("abort_done", 64'(Done), 64'd0);
      chk("abort_res", {Result2, Result1}, 64'd0);
      saw = 1'b0;
      repeat (45) begin
         @(negedge CLK);
         if (Done) saw = 1'b1;
      end
      chk("abort_no_done", 64'(saw), 64'd0);
      last_res = 64'd0;

      run_op(2'd3, 32'h0000_0064, 32'h0000_0007, 1'b0, t1);
      @(negedge CLK);
      chk("done_single", 64'(Done), 64'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
